// File: rtl/toaplan2_gfx_arbiter.sv
// Four-slot round-robin arbiter issuing 32-bit (two-word) SDRAM bursts into per-slot tagged data registers.
// Optional: define TOAPLAN2_GFX_ARB_CACHE_EN to keep slot data valid while the slot's CS is low.
module toaplan2_gfx_arbiter #(
    parameter int SDRAMW = 22,
    parameter int AW     = 22
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [3:0]        SLOT_CS,
    input  logic [4*AW-1:0]   SLOT_ADDR,
    output logic [3:0]        SLOT_OK,
    output logic [127:0]      SLOT_DOUT,
    output logic [SDRAMW-1:0] SDRAM_ADDR,
    output logic              SDRAM_REQ,
    input  logic              SDRAM_ACK,
    input  logic              DATA_DST,
    input  logic              DATA_RDY,
    input  logic [15:0]       DATA_READ
);
    localparam int TW = AW - 1;
    localparam int XW = (SDRAMW > AW) ? SDRAMW : AW;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;
    state_t r_state, w_state_nx;

    logic [TW-1:0]     r_tag [4];
    logic [31:0]       r_data [4];
    logic [3:0]        r_valid;
    logic [1:0]        r_last;
    logic [1:0]        r_slot;
    logic [TW-1:0]     r_btag;
    logic [SDRAMW-1:0] r_addr;
    logic              r_req;
    logic [1:0]        r_wcnt;
    logic [15:0]       r_lo;
    logic [15:0]       r_hi;

    logic [TW-1:0]     w_tag_in [4];
    logic [3:0]        w_hit;
    logic [3:0]        w_pend;
    logic              w_found;
    logic [1:0]        w_pick;
    logic [1:0]        w_idx;
    logic [15:0]       w_lo;
    logic [15:0]       w_hi;
    logic [XW-1:0]     w_addr_ext;

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            w_tag_in[n] = SLOT_ADDR[n*AW+1 +: TW];
            w_hit[n]    = r_valid[n] && (r_tag[n] == w_tag_in[n]);
            w_pend[n]   = SLOT_CS[n] && !w_hit[n];
        end
    end

    // Search order starts one past the last grant so a busy slot cannot starve the others.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last + 2'd1;
        w_idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && w_pend[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_addr_ext = XW'({w_tag_in[w_pick], 1'b0});

    // A DST arriving with RDY is merged in before the slot register is written.
    always_comb begin
        w_lo = r_lo;
        w_hi = r_hi;
        if (DATA_DST) begin
            if (r_wcnt == 2'd0)
                w_lo = DATA_READ;
            else if (r_wcnt == 2'd1)
                w_hi = DATA_READ;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_found)   w_state_nx = ST_REQ;
            ST_REQ:  if (SDRAM_ACK) w_state_nx = ST_DATA;
            ST_DATA: if (DATA_RDY)  w_state_nx = ST_IDLE;
            default:                w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_valid <= '0;
            r_last  <= 2'd3;
            r_slot  <= '0;
            r_btag  <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_wcnt  <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                r_tag[n]  <= '0;
                r_data[n] <= '0;
            end
        end else begin
`ifndef TOAPLAN2_GFX_ARB_CACHE_EN
            for (int unsigned n = 0; n < 4; n++)
                if (!SLOT_CS[n] && !(r_state != ST_IDLE && r_slot == 2'(n)))
                    r_valid[n] <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_slot <= w_pick;
                        r_last <= w_pick;
                        r_btag <= w_tag_in[w_pick];
                        r_addr <= w_addr_ext[SDRAMW-1:0];
                        r_req  <= 1'b1;
                        r_wcnt <= '0;
                        r_lo   <= '0;
                        r_hi   <= '0;
                    end
                end
                ST_REQ: begin
                    if (SDRAM_ACK)
                        r_req <= 1'b0;
                end
                ST_DATA: begin
                    r_lo <= w_lo;
                    r_hi <= w_hi;
                    if (DATA_DST && r_wcnt != 2'd2)
                        r_wcnt <= r_wcnt + 2'd1;
                    if (DATA_RDY) begin
                        r_data[r_slot]  <= {w_hi, w_lo};
                        r_tag[r_slot]   <= r_btag;
                        r_valid[r_slot] <= 1'b1;
                        r_wcnt          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SLOT_OK   = '0;
        SLOT_DOUT = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            SLOT_OK[n]           = RESET_N && SLOT_CS[n] && w_hit[n];
            SLOT_DOUT[n*32 +: 32] = r_data[n];
        end
    end

    assign SDRAM_REQ  = r_req;
    assign SDRAM_ADDR = r_addr;

endmodule

// File: tb/tb_toaplan2_gfx_arbiter.sv
// Directed bench for toaplan2_gfx_arbiter: a table of single-slot fetches plus hand sequences for
// round-robin, mid-burst address change, reset mid-burst, CS drop/reassert, fairness and extra DST pulses.
`timescale 1ns/1ps
module tb_toaplan2_gfx_arbiter;
    localparam int AW = 22;
    localparam int SW = 22;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      cs;
    logic [4*AW-1:0] addr;
    logic [3:0]      ok;
    logic [127:0]    dout;
    logic [SW-1:0]   sd_addr;
    logic            sd_req;
    logic            ack;
    logic            dst;
    logic            rdy;
    logic [15:0]     rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]    slot;
        logic [AW-1:0] addr;
        int            ack_dly;
        logic [15:0]   w0;
        logic [15:0]   w1;
        logic [SW-1:0] exp_sdaddr;
        logic [31:0]   exp_dout;
    } vec_t;

    always #5 clk = ~clk;

    toaplan2_gfx_arbiter #(.SDRAMW(SW), .AW(AW)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .SLOT_CS    (cs),
        .SLOT_ADDR  (addr),
        .SLOT_OK    (ok),
        .SLOT_DOUT  (dout),
        .SDRAM_ADDR (sd_addr),
        .SDRAM_REQ  (sd_req),
        .SDRAM_ACK  (ack),
        .DATA_DST   (dst),
        .DATA_RDY   (rdy),
        .DATA_READ  (rd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        addr[s*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cs = '0; ack = 1'b0; dst = 1'b0; rdy = 1'b0; rd = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_req(input string name);
        int unsigned i;
        i = 0;
        #1;
        while (sd_req !== 1'b1 && i < 20) begin
            cyc(); #1;
            i++;
        end
        check($sformatf("%s_req_seen", name), sd_req, 1);
    endtask

    // Plays the controller: optional ACK delay, then two words, then n_extra surplus DST pulses.
    task automatic serve(input string name, input int ack_dly, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [SW-1:0] exp_addr, input int n_extra);
        for (int i = 0; i < ack_dly; i++) begin
            cyc(); #1;
            check($sformatf("%s_req_hold", name), {sd_req, sd_addr}, {1'b1, exp_addr});
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0; #1;
        check($sformatf("%s_req_drop", name), sd_req, 0);
        dst = 1'b1; rd = w0;
        cyc();
        rd = w1; rdy = (n_extra == 0);
        cyc();
        for (int i = 0; i < n_extra; i++) begin
            rd = 16'(16'hEEE0 + i); rdy = (i == n_extra - 1);
            cyc();
        end
        dst = 1'b0; rdy = 1'b0; rd = '0; #1;
    endtask

    initial begin
        vec_t tbl [4];
        tbl[0] = '{2'd2, 22'h000101, 3, 16'h1234, 16'h5678, 22'h000100, 32'h56781234};
        tbl[1] = '{2'd0, 22'h3FFFFF, 0, 16'hFFFF, 16'h0001, 22'h3FFFFE, 32'h0001FFFF};
        tbl[2] = '{2'd1, 22'h000000, 1, 16'hA5A5, 16'h5A5A, 22'h000000, 32'h5A5AA5A5};
        tbl[3] = '{2'd3, 22'h2AAAAB, 2, 16'hDEAD, 16'hBEEF, 22'h2AAAAA, 32'hBEEFDEAD};

        // Reset state, with all CS high during reset
        rst_n = 1'b0; cs = 4'hF; addr = '0; ack = 1'b0; dst = 1'b0; rdy = 1'b0; rd = '0;
        cyc(); cyc(); #1;
        check("rst_req", sd_req, 0);
        check("rst_addr", sd_addr, 0);
        check("rst_ok", ok, 0);
        check("rst_dout", |dout, 0);
        cs = '0; rst_n = 1'b1;
        cyc();

        // Table of single-slot fetches
        for (int v = 0; v < 4; v++) begin
            set_addr(tbl[v].slot, tbl[v].addr);
            cs = 4'b0001 << tbl[v].slot; #1;
            check("tbl_pre", sd_req, 0);
            cyc(); #1;
            check("tbl_latency", sd_req, 1);
            check("tbl_sdaddr", sd_addr, tbl[v].exp_sdaddr);
            serve("tbl", tbl[v].ack_dly, tbl[v].w0, tbl[v].w1, tbl[v].exp_sdaddr, 0);
            check("tbl_ok", ok, 4'b0001 << tbl[v].slot);
            check("tbl_dout", dout[tbl[v].slot*32 +: 32], tbl[v].exp_dout);
            cs = '0;
            cyc();
        end

        // All four slots from reset: grants 0,1,2,3 with a gap between bursts
        do_reset();
        for (int s = 0; s < 4; s++) set_addr(s, 22'(22'h100 + s*4));
        cs = 4'hF;
        for (int g = 0; g < 4; g++) begin
            wait_req("rr");
            check("rr_order", sd_addr, 22'h100 + g*4);
            serve("rr", 1, 16'(16'h1000 + g), 16'(16'h2000 + g), 22'(22'h100 + g*4), 0);
            check("rr_gap", sd_req, 0);
            cyc();
        end
        #1;
        check("rr_ok_all", ok, 4'hF);
        check("rr_dout3", dout[127:96], 32'h20031003);
        check("rr_idle", sd_req, 0);

        // Slot 0 address changes during DATA
        do_reset();
        set_addr(0, 22'h10); cs = 4'b0001;
        wait_req("chg");
        check("chg_addr1", sd_addr, 22'h10);
        ack = 1'b1; cyc(); ack = 1'b0;
        set_addr(0, 22'h20);
        dst = 1'b1; rd = 16'hAAAA; cyc();
        rd = 16'hBBBB; rdy = 1'b1; cyc();
        dst = 1'b0; rdy = 1'b0; #1;
        check("chg_ok_low", ok, 0);
        check("chg_dout1", dout[31:0], 32'hBBBBAAAA);
        cyc(); #1;
        check("chg_req2", {sd_req, sd_addr}, {1'b1, 22'h20});
        serve("chg2", 0, 16'hCCCC, 16'hDDDD, 22'h20, 0);
        check("chg_ok", ok, 4'b0001);
        check("chg_dout2", dout[31:0], 32'hDDDDCCCC);

        // Reset asserted in DATA, coinciding with the final word
        do_reset();
        set_addr(1, 22'h40); cs = 4'b0010;
        wait_req("rmb");
        ack = 1'b1; cyc(); ack = 1'b0;
        dst = 1'b1; rd = 16'h1111; cyc();
        rd = 16'h2222; rdy = 1'b1; rst_n = 1'b0; cyc();
        dst = 1'b0; rdy = 1'b0; #1;
        check("rmb_req", sd_req, 0);
        check("rmb_ok", ok, 0);
        rst_n = 1'b1;
        cyc(); #1;
        check("rmb_ok_after", ok, 0);
        check("rmb_dout", dout[63:32], 0);
        check("rmb_refetch", sd_req, 1);

        // Slot 1 CS drops for 5 cycles and returns at the same address
        do_reset();
        set_addr(1, 22'h55); cs = 4'b0010;
        wait_req("cch");
        serve("cch", 0, 16'h0F0F, 16'hF0F0, 22'h54, 0);
        check("cch_ok", ok, 4'b0010);
        cs = '0;
        repeat (5) cyc();
        #1;
        check("cch_idle", sd_req, 0);
        cs = 4'b0010; #1;
`ifdef TOAPLAN2_GFX_ARB_CACHE_EN
        check("cch_hit_ok", ok, 4'b0010);
        cyc(); #1;
        check("cch_noreq", sd_req, 0);
`else
        check("cch_miss_ok", ok, 0);
        cyc(); #1;
        check("cch_refetch", {sd_req, sd_addr}, {1'b1, 22'h54});
        serve("cch2", 0, 16'h0F0F, 16'hF0F0, 22'h54, 0);
        check("cch_ok2", ok, 4'b0010);
`endif

        // Slot 3 arrives while slot 0 is mid-burst and slot 0 keeps moving its address
        do_reset();
        set_addr(0, 22'h200); cs = 4'b0001;
        wait_req("fair");
        ack = 1'b1; cyc(); ack = 1'b0;
        set_addr(3, 22'h300); set_addr(0, 22'h210); cs = 4'b1001;
        dst = 1'b1; rd = 16'h0001; cyc();
        rd = 16'h0002; rdy = 1'b1; cyc();
        dst = 1'b0; rdy = 1'b0; #1;
        check("fair_ok0", ok, 0);
        cyc(); #1;
        check("fair_grant3", {sd_req, sd_addr}, {1'b1, 22'h300});
        serve("fair3", 0, 16'h3333, 16'h4444, 22'h300, 0);
        check("fair_ok3", ok, 4'b1000);
        cyc(); #1;
        check("fair_grant0", {sd_req, sd_addr}, {1'b1, 22'h210});

        // Surplus DST pulses after the second word are ignored
        serve("xtra", 0, 16'h1111, 16'h2222, 22'h210, 2);
        check("xtra_ok", ok, 4'b1001);
        check("xtra_dout", dout[31:0], 32'h22221111);
        check("xtra_dout3", dout[127:96], 32'h44443333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
